request_scheduler: RTL and testbench

Upstream request stage of the elevator datapath: latches floor-call buttons into a pending-request set and decides the next target floor using a SCAN (collective) policy. Its target floor drives the floor comparator, and its current-floor input comes back from the stage counter. It also owns door timing: it holds the car stopped at each served floor for a fixed number of ticks before choosing the next target.

---
 rtl/request_scheduler.sv | 178 +++++++++++++++++
 tb/tb_request_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_scheduler.sv
// Purpose : latches floor calls into a pending set and picks the next target floor (SCAN policy), owns door dwell.
// Latency : REQ visible on PENDING after 1 edge, FSM/TARGET react 1 edge later; CUR_FLOOR reacts in 1 edge.
// Backpr. : none; REQ is level-sensitive and every output is a registered level.
// Ports   : CLOCK_50/RESET clock and async active-high reset; TICK dwell step enable; REQ call buttons;
//           CUR_FLOOR car position; TARGET/TARGET_VALID travel target; DIR_UP direction memory;
//           DOOR_OPEN door state; PENDING registered request set.
module request_scheduler #(
  parameter int FLOORS = 10,
  parameter int DWELL  = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              TICK,
  input  logic [FLOORS-1:0] REQ,
  input  logic [3:0]        CUR_FLOOR,
  output logic [3:0]        TARGET,
  output logic              TARGET_VALID,
  output logic              DIR_UP,
  output logic              DOOR_OPEN,
  output logic [FLOORS-1:0] PENDING
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR
  } state_t;

  localparam logic [4:0] FLOORS_W = 5'(FLOORS);
  localparam logic [3:0] DWELL_W  = 4'(DWELL);

  state_t            state_q, state_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [3:0]        target_q, target_d;
  logic [3:0]        dwell_q, dwell_d;
  logic              dir_up_q, dir_up_d;
  logic              tgt_vld_q, tgt_vld_d;
  logic              door_q, door_d;

  logic       cur_valid;
  logic       here, above, below, here_req;
  logic [3:0] lo_above, hi_below;
  logic [3:0] up_dist, dn_dist;

  assign cur_valid = ({1'b0, CUR_FLOOR} < FLOORS_W);

  // Scan the pending set relative to the car. An out-of-range floor sees nothing.
  always_comb begin
    above    = 1'b0;
    below    = 1'b0;
    here     = 1'b0;
    here_req = 1'b0;
    lo_above = 4'd0;
    hi_below = 4'd0;
    // Descending walk: last hit is the lowest pending floor above the car.
    for (int j = FLOORS - 1; j >= 0; j--) begin
      if (cur_valid && pending_q[j] && (4'(j) > CUR_FLOOR)) begin
        above    = 1'b1;
        lo_above = 4'(j);
      end
    end
    // Ascending walk: last hit is the highest pending floor below the car.
    for (int j = 0; j < FLOORS; j++) begin
      if (cur_valid && pending_q[j] && (4'(j) < CUR_FLOOR)) begin
        below    = 1'b1;
        hi_below = 4'(j);
      end
      if (cur_valid && (4'(j) == CUR_FLOOR)) begin
        here     = pending_q[j];
        here_req = REQ[j];
      end
    end
  end

  assign up_dist = lo_above - CUR_FLOOR;
  assign dn_dist = CUR_FLOOR - hi_below;

  // Next-state, dwell counter and direction memory. Invalid floor freezes all of it.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    dir_up_d = dir_up_q;
    if (cur_valid) begin
      case (state_q)
        S_IDLE: begin
          if (here)                state_d = S_DOOR;
          else if (above && below) state_d = (up_dist <= dn_dist) ? S_MOVE_UP : S_MOVE_DOWN;
          else if (above)          state_d = S_MOVE_UP;
          else if (below)          state_d = S_MOVE_DOWN;
        end
        S_MOVE_UP: begin
          if (here)        state_d = S_DOOR;
          else if (!above) state_d = S_IDLE;
        end
        S_MOVE_DOWN: begin
          if (here)        state_d = S_DOOR;
          else if (!below) state_d = S_IDLE;
        end
        S_DOOR: begin
          // A fresh call at this floor restarts the dwell and takes priority over leaving.
          if (here_req) begin
            dwell_d = DWELL_W;
          end else if (TICK) begin
            dwell_d = dwell_q - 4'd1;
            if (dwell_q == 4'd1) begin
              if (dir_up_q) begin
                if (above)      state_d = S_MOVE_UP;
                else if (below) state_d = S_MOVE_DOWN;
                else            state_d = S_IDLE;
              end else begin
                if (below)      state_d = S_MOVE_DOWN;
                else if (above) state_d = S_MOVE_UP;
                else            state_d = S_IDLE;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if ((state_d == S_DOOR) && (state_q != S_DOOR)) dwell_d = DWELL_W;
      if (state_d == S_MOVE_UP)   dir_up_d = 1'b1;
      if (state_d == S_MOVE_DOWN) dir_up_d = 1'b0;
    end
  end

  // Outputs are computed from the next state so the registered values track it.
  always_comb begin
    target_d  = target_q;
    tgt_vld_d = (state_d == S_MOVE_UP) || (state_d == S_MOVE_DOWN);
    door_d    = (state_d == S_DOOR);
    if (cur_valid) begin
      case (state_d)
        S_MOVE_UP:   target_d = lo_above;
        S_MOVE_DOWN: target_d = hi_below;
        default:     target_d = CUR_FLOOR;
      endcase
    end
  end

  // Set wins over clear except for the car's own floor while in or entering DOOR.
  always_comb begin
    pending_d = pending_q | REQ;
    for (int j = 0; j < FLOORS; j++) begin
      if (cur_valid && (4'(j) == CUR_FLOOR) &&
          ((state_q == S_DOOR) || (state_d == S_DOOR))) begin
        pending_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      target_q  <= 4'd0;
      dwell_q   <= 4'd0;
      dir_up_q  <= 1'b1;
      tgt_vld_q <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dwell_q   <= dwell_d;
      dir_up_q  <= dir_up_d;
      tgt_vld_q <= tgt_vld_d;
      door_q    <= door_d;
    end
  end

  assign TARGET       = target_q;
  assign TARGET_VALID = tgt_vld_q;
  assign DIR_UP       = dir_up_q;
  assign DOOR_OPEN    = door_q;
  assign PENDING      = pending_q;

endmodule

// File: tb/tb_request_scheduler.sv
// Purpose : scenario bench for request_scheduler (FLOORS=10, DWELL=8) with an expectation queue.
// Latency : inputs driven and outputs sampled on the falling edge, half a cycle away from the active edge.
// Backpr. : not applicable.
module tb_request_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [9:0] req = '0;
  logic [3:0] cur = 4'd0;
  logic [3:0] target;
  logic       tgt_vld, dir_up, door_open;
  logic [9:0] pending;
  logic [16:0] obs;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  request_scheduler #(.FLOORS(10), .DWELL(8)) dut (
    .CLOCK_50    (clk),
    .RESET       (rst),
    .TICK        (tick),
    .REQ         (req),
    .CUR_FLOOR   (cur),
    .TARGET      (target),
    .TARGET_VALID(tgt_vld),
    .DIR_UP      (dir_up),
    .DOOR_OPEN   (door_open),
    .PENDING     (pending)
  );

  always #5 clk = ~clk;

  assign obs = {target, tgt_vld, dir_up, door_open, pending};

  function automatic exp_t mk(string n, logic [3:0] t, logic v, logic d, logic o, logic [9:0] p);
    exp_t e;
    e.name = n;
    e.v    = {t, v, d, o, p};
    return e;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each TICK is a one-cycle pulse followed by one idle cycle.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    exp_t e;
    exp_q.push_back(mk("reset_values", 4'd0, 1'b0, 1'b1, 1'b0, 10'h000));
    cyc(2);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    rst = 1'b0;
    cyc(1);
    req = 10'h00B;
    cyc(1);
    req = 10'h000;
    exp_q.push_back(mk("door_before_reset", 4'd0, 1'b0, 1'b1, 1'b1, 10'h00A));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    rst = 1'b1;
    exp_q.push_back(mk("async_reset_mid_door", 4'd0, 1'b0, 1'b1, 1'b0, 10'h000));
    #2;
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    cyc(2);
    rst = 1'b0;
    exp_q.push_back(mk("after_reset_release", 4'd0, 1'b0, 1'b1, 1'b0, 10'h000));
    cyc(2);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_single_up;
    exp_t e;
    cur = 4'd2;
    req = 10'h020;
    exp_q.push_back(mk("up_pending_latched", 4'd2, 1'b0, 1'b1, 1'b0, 10'h020));
    cyc(1);
    req = 10'h000;
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    exp_q.push_back(mk("up_move", 4'd5, 1'b1, 1'b1, 1'b0, 10'h020));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    cur = 4'd5;
    exp_q.push_back(mk("up_arrive_door", 4'd5, 1'b0, 1'b1, 1'b1, 10'h000));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    exp_q.push_back(mk("dwell_7_ticks_open", 4'd5, 1'b0, 1'b1, 1'b1, 10'h000));
    ticks(7);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    exp_q.push_back(mk("dwell_8_ticks_idle", 4'd5, 1'b0, 1'b1, 1'b0, 10'h000));
    ticks(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_intermediate_stop;
    exp_t e;
    cur = 4'd1;
    req = 10'h088;
    cyc(1);
    req = 10'h000;
    exp_q.push_back(mk("inter_target_3", 4'd3, 1'b1, 1'b1, 1'b0, 10'h088));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    cur = 4'd2;
    cyc(1);
    cur = 4'd3;
    exp_q.push_back(mk("inter_door_at_3", 4'd3, 1'b0, 1'b1, 1'b1, 10'h080));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    exp_q.push_back(mk("inter_resume_to_7", 4'd7, 1'b1, 1'b1, 1'b0, 10'h080));
    ticks(8);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    cur = 4'd7;
    cyc(1);
    exp_q.push_back(mk("inter_idle_at_7", 4'd7, 1'b0, 1'b1, 1'b0, 10'h000));
    ticks(8);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_direction_priority;
    exp_t e;
    cur = 4'd4;
    req = 10'h010;
    cyc(1);
    req = 10'h000;
    cyc(1);
    req = 10'h044;
    exp_q.push_back(mk("dir_door_with_2_6", 4'd4, 1'b0, 1'b1, 1'b1, 10'h044));
    cyc(1);
    req = 10'h000;
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    exp_q.push_back(mk("dir_exit_up_6", 4'd6, 1'b1, 1'b1, 1'b0, 10'h044));
    ticks(8);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    cur = 4'd5;
    cyc(1);
    cur = 4'd6;
    cyc(1);
    exp_q.push_back(mk("dir_exit_down_2", 4'd2, 1'b1, 1'b0, 1'b0, 10'h004));
    ticks(8);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    cur = 4'd2;
    cyc(1);
    exp_q.push_back(mk("dir_idle_at_2", 4'd2, 1'b0, 1'b0, 1'b0, 10'h000));
    ticks(8);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_nearest;
    exp_t e;
    cur = 4'd5;
    req = 10'h208;
    cyc(1);
    req = 10'h000;
    exp_q.push_back(mk("nearest_down_3", 4'd3, 1'b1, 1'b0, 1'b0, 10'h208));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    req = 10'h088;
    cyc(1);
    req = 10'h000;
    exp_q.push_back(mk("tie_goes_up_7", 4'd7, 1'b1, 1'b1, 1'b0, 10'h088));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    rst = 1'b1;
    cur = 4'd0;
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_door_reload;
    exp_t e;
    req = 10'h001;
    exp_q.push_back(mk("here_req_pending", 4'd0, 1'b0, 1'b1, 1'b0, 10'h001));
    cyc(1);
    req = 10'h000;
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    exp_q.push_back(mk("here_req_door", 4'd0, 1'b0, 1'b1, 1'b1, 10'h000));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    ticks(5);
    req = 10'h001;
    exp_q.push_back(mk("reload_pending_clear", 4'd0, 1'b0, 1'b1, 1'b1, 10'h000));
    cyc(1);
    req = 10'h000;
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    exp_q.push_back(mk("reload_7_ticks_open", 4'd0, 1'b0, 1'b1, 1'b1, 10'h000));
    ticks(7);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    exp_q.push_back(mk("reload_8_ticks_idle", 4'd0, 1'b0, 1'b1, 1'b0, 10'h000));
    ticks(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  task automatic test_invalid_floor;
    exp_t e;
    req = 10'h100;
    cyc(1);
    req = 10'h000;
    exp_q.push_back(mk("inv_move_to_8", 4'd8, 1'b1, 1'b1, 1'b0, 10'h100));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    cur = 4'd12;
    req = 10'h002;
    cyc(1);
    req = 10'h000;
    exp_q.push_back(mk("inv_floor_holds", 4'd8, 1'b1, 1'b1, 1'b0, 10'h102));
    cyc(2);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
    cur = 4'd8;
    exp_q.push_back(mk("inv_recover_door_8", 4'd8, 1'b0, 1'b1, 1'b1, 10'h002));
    cyc(1);
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e.v) begin n_errors++; $display("FAIL %s: got %h expected %h", e.name, obs, e.v); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_up();
    test_intermediate_stop();
    test_direction_priority();
    test_nearest();
    test_door_reload();
    test_invalid_floor();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
